// File: rtl/num_test_pkg.sv
// Shared constants for the 7-segment loopback checker.
//   Segment codes are {a,b,c,d,e,f,g,dp}, bit 7 = a.
//   Symbol codes: 0-9 digits, SYM_F = "8." (all segments), SYM_BAD = illegal.
package num_test_pkg;

  localparam logic [7:0] SEG_D0  = 8'hfc;
  localparam logic [7:0] SEG_D1  = 8'h60;
  localparam logic [7:0] SEG_D2  = 8'hda;
  localparam logic [7:0] SEG_D3  = 8'hf2;
  localparam logic [7:0] SEG_D4  = 8'h66;
  localparam logic [7:0] SEG_D5  = 8'hb6;
  localparam logic [7:0] SEG_D6  = 8'hbe;
  localparam logic [7:0] SEG_D7  = 8'he0;
  localparam logic [7:0] SEG_D8  = 8'hfe;
  localparam logic [7:0] SEG_D9  = 8'hf6;
  localparam logic [7:0] SEG_ALL = 8'hff;

  localparam logic [3:0] SYM_F   = 4'hF;
  localparam logic [3:0] SYM_BAD = 4'hE;

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Decoded symbol payload
  typedef struct packed {
    logic       illegal;
    logic [3:0] val;
  } dec_t;

endpackage

// File: rtl/num_seg_decode.sv
// Combinational segment-pattern lookup.
//   seg       : 8-bit segment pattern {a..g,dp}
//   illegal_c : pattern is not in the table
//   val_c     : 0-9, SYM_F for "8.", SYM_BAD otherwise
module num_seg_decode
  import num_test_pkg::*;
(
  input  logic [7:0] seg,
  output logic       illegal_c,
  output logic [3:0] val_c
);

  dec_t d;

  // Pattern to symbol table
  always_comb begin
    d.illegal = 1'b0;
    d.val     = 4'd0;
    case (seg)
      SEG_D0:  d.val = 4'd0;
      SEG_D1:  d.val = 4'd1;
      SEG_D2:  d.val = 4'd2;
      SEG_D3:  d.val = 4'd3;
      SEG_D4:  d.val = 4'd4;
      SEG_D5:  d.val = 4'd5;
      SEG_D6:  d.val = 4'd6;
      SEG_D7:  d.val = 4'd7;
      SEG_D8:  d.val = 4'd8;
      SEG_D9:  d.val = 4'd9;
      SEG_ALL: d.val = SYM_F;
      default: begin
        d.illegal = 1'b1;
        d.val     = SYM_BAD;
      end
    endcase
  end

  assign illegal_c = d.illegal;
  assign val_c     = d.val;

endmodule

// File: rtl/num_seg_rx_check.sv
// 7-segment loopback receiver: synchronizes seg_in, decodes it, locks onto
// the 16-symbol display-test sequence (0..9 then six "8.") and counts errors
// and clean frames.
//   clk_div8M, rstn : clock, async active-low reset
//   seg_in          : looped-back segment lines
//   dec_val/dec_vld/dec_illegal : decoded symbol, SYNC_STAGES+1 cycles latency
//   locked          : checker in LOCKED
//   err_flag        : mismatch pulse, or sticky when NUM_SEG_RX_ERR_STICKY_EN
//   err_cnt         : saturating mismatch count while locked
//   frame_cnt       : wrapping count of error-free frames
// Build option: NUM_SEG_RX_ERR_STICKY_EN makes err_flag hold until reset.
module num_seg_rx_check
  import num_test_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOSS_THRESH = 3,
  parameter int unsigned ERR_W       = 8,
  parameter int unsigned FRM_W       = 8
) (
  input  logic             clk_div8M,
  input  logic             rstn,
  input  logic [7:0]       seg_in,
  output logic [3:0]       dec_val,
  output logic             dec_vld,
  output logic             dec_illegal,
  output logic             locked,
  output logic             err_flag,
  output logic [ERR_W-1:0] err_cnt,
  output logic [FRM_W-1:0] frame_cnt
);

  localparam int unsigned RUN_W = $clog2(LOSS_THRESH + 1);

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [SYNC_STAGES:0]        fill_q;
  logic                        dec_illegal_c;
  logic [3:0]                  dec_val_c;

  logic [0:0]       state_q, state_nxt;
  logic [3:0]       exp_idx_q, exp_idx_nxt;
  logic [RUN_W-1:0] miss_run_q, miss_run_nxt;
  logic             frame_err_q, frame_err_nxt;
  logic             prev_is_f;
  logic [ERR_W-1:0] err_cnt_nxt;
  logic [FRM_W-1:0] frame_cnt_nxt;
  logic             err_flag_nxt;
  logic             locked_nxt;
  logic [3:0]       exp_sym;
  logic             mismatch;
  logic [RUN_W-1:0] run_inc;

  num_seg_decode u_decode (
    .seg       (sync_q[SYNC_STAGES-1]),
    .illegal_c (dec_illegal_c),
    .val_c     (dec_val_c)
  );

  // Synchronizer chain plus fill tracker; decode register loads only once
  // the last sync stage carries post-reset data, so outputs stay 0 until then.
  always_ff @(posedge clk_div8M or negedge rstn) begin
    if (!rstn) begin
      sync_q      <= '0;
      fill_q      <= '0;
      dec_val     <= 4'd0;
      dec_illegal <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], seg_in};
      fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
      if (fill_q[SYNC_STAGES-1]) begin
        dec_val     <= dec_val_c;
        dec_illegal <= dec_illegal_c;
      end
    end
  end

  assign dec_vld = fill_q[SYNC_STAGES];

  // Lock state machine, counters and their next values
  always_comb begin
    state_nxt     = state_q;
    exp_idx_nxt   = exp_idx_q;
    miss_run_nxt  = miss_run_q;
    frame_err_nxt = frame_err_q;
    err_cnt_nxt   = err_cnt;
    frame_cnt_nxt = frame_cnt;
`ifdef NUM_SEG_RX_ERR_STICKY_EN
    err_flag_nxt  = err_flag;
`else
    err_flag_nxt  = 1'b0;
`endif
    exp_sym  = (exp_idx_q <= 4'd9) ? exp_idx_q : SYM_F;
    mismatch = (dec_val != exp_sym);
    run_inc  = miss_run_q + RUN_W'(1);

    case (state_q)
      ST_HUNT: begin
        if (dec_vld && dec_val == 4'd0 && prev_is_f) begin
          state_nxt     = ST_LOCKED;
          exp_idx_nxt   = 4'd1;
          frame_err_nxt = 1'b0;
          miss_run_nxt  = '0;
        end
      end
      ST_LOCKED: begin
        if (dec_vld) begin
          exp_idx_nxt = exp_idx_q + 4'd1;
          if (mismatch) begin
            if (err_cnt != '1) err_cnt_nxt = err_cnt + ERR_W'(1);
            err_flag_nxt  = 1'b1;
            frame_err_nxt = 1'b1;
            miss_run_nxt  = run_inc;
          end else begin
            miss_run_nxt = '0;
          end
          // Loss of lock outranks the frame-boundary bookkeeping
          if (mismatch && run_inc == RUN_W'(LOSS_THRESH)) begin
            state_nxt    = ST_HUNT;
            miss_run_nxt = '0;
          end else if (exp_idx_q == 4'd15) begin
            if (!mismatch && !frame_err_q) frame_cnt_nxt = frame_cnt + FRM_W'(1);
            frame_err_nxt = 1'b0;
          end
        end
      end
      default: state_nxt = ST_HUNT;
    endcase

    locked_nxt = (state_nxt == ST_LOCKED);
  end

  // State and counter registers
  always_ff @(posedge clk_div8M or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_HUNT;
      exp_idx_q   <= 4'd0;
      miss_run_q  <= '0;
      frame_err_q <= 1'b0;
      prev_is_f   <= 1'b0;
      err_cnt     <= '0;
      frame_cnt   <= '0;
      err_flag    <= 1'b0;
      locked      <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      exp_idx_q   <= exp_idx_nxt;
      miss_run_q  <= miss_run_nxt;
      frame_err_q <= frame_err_nxt;
      prev_is_f   <= dec_vld && (dec_val == SYM_F);
      err_cnt     <= err_cnt_nxt;
      frame_cnt   <= frame_cnt_nxt;
      err_flag    <= err_flag_nxt;
      locked      <= locked_nxt;
    end
  end

endmodule

// File: tb/tb_num_seg_rx_check.sv
// Randomized self-checking bench for num_seg_rx_check against a symbol-level
// reference model of the display-test lock/count rules.
module tb_num_seg_rx_check;

  localparam int LOSS = 3;

  logic       clk_div8M = 1'b0;
  logic       rstn;
  logic [7:0] seg_in;
  logic [3:0] dec_val;
  logic       dec_vld;
  logic       dec_illegal;
  logic       locked;
  logic       err_flag;
  logic [7:0] err_cnt;
  logic [7:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] PAT [0:9] = '{8'hfc, 8'h60, 8'hda, 8'hf2, 8'h66,
                                       8'hb6, 8'hbe, 8'he0, 8'hfe, 8'hf6};

  num_seg_rx_check dut (
    .clk_div8M   (clk_div8M),
    .rstn        (rstn),
    .seg_in      (seg_in),
    .dec_val     (dec_val),
    .dec_vld     (dec_vld),
    .dec_illegal (dec_illegal),
    .locked      (locked),
    .err_flag    (err_flag),
    .err_cnt     (err_cnt),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk_div8M = ~clk_div8M;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_of(input int pos);
    return (pos <= 9) ? PAT[pos] : 8'hff;
  endfunction

  // Returns symbol value; 14 for anything outside the table
  function automatic int ref_decode(input logic [7:0] p);
    for (int i = 0; i < 10; i++) if (PAT[i] == p) return i;
    if (p == 8'hff) return 15;
    return 14;
  endfunction

  function automatic logic [7:0] pick_bad(input logic [7:0] good);
    logic [7:0] v;
    v = 8'($urandom);
    while (v == good) v = 8'($urandom);
    return v;
  endfunction

  // ---------------- reference model ----------------
  int  m_k;                         // edges since reset release
  logic [7:0] m_s0, m_s1;           // last two sampled inputs
  int  m_val, m_ill, m_vld;
  int  m_locked, m_idx, m_run, m_prevf, m_ferr, m_err, m_frm, m_flag;

  always @(posedge clk_div8M or negedge rstn) begin
    if (!rstn) begin
      m_k = 0; m_s0 = 0; m_s1 = 0;
      m_val = 0; m_ill = 0; m_vld = 0;
      m_locked = 0; m_idx = 0; m_run = 0; m_prevf = 0;
      m_ferr = 0; m_err = 0; m_frm = 0; m_flag = 0;
    end else begin
      int  exp_s;
      bit  bad;
      bad = 0;
      if (m_vld != 0) begin
        if (m_locked == 0) begin
          if (m_val == 0 && m_prevf != 0) begin
            m_locked = 1; m_idx = 1; m_ferr = 0; m_run = 0;
          end
        end else begin
          exp_s = (m_idx <= 9) ? m_idx : 15;
          bad = (m_val != exp_s);
          if (bad) begin
            if (m_err < 255) m_err++;
            m_run++;
          end else begin
            m_run = 0;
          end
          if (bad && m_run >= LOSS) begin
            m_locked = 0;
            m_run = 0;
            m_ferr = 1;
          end else if (m_idx == 15) begin
            if (!bad && m_ferr == 0) m_frm = (m_frm + 1) % 256;
            m_ferr = 0;
          end else if (bad) begin
            m_ferr = 1;
          end
          m_idx = (m_idx + 1) % 16;
        end
      end
`ifdef NUM_SEG_RX_ERR_STICKY_EN
      if (bad) m_flag = 1;
`else
      m_flag = bad ? 1 : 0;
`endif
      m_prevf = (m_vld != 0 && m_val == 15) ? 1 : 0;
      // decode stage: symbol sampled two edges ago appears on the third edge
      if (m_k >= 2) begin
        m_val = ref_decode(m_s1);
        m_ill = (m_val == 14) ? 1 : 0;
        m_vld = 1;
      end
      m_s1 = m_s0;
      m_s0 = seg_in;
      if (m_k < 3) m_k++;
    end
  end

  // Cycle-by-cycle comparison away from the active edge
  bit cmp_en = 0;
  always @(negedge clk_div8M) begin
    if (cmp_en && rstn) begin
      chk("dec_vld",     int'(dec_vld),     m_vld);
      chk("dec_val",     int'(dec_val),     m_val);
      chk("dec_illegal", int'(dec_illegal), m_ill);
      chk("locked",      int'(locked),      m_locked);
      chk("err_flag",    int'(err_flag),    m_flag);
      chk("err_cnt",     int'(err_cnt),     m_err);
      chk("frame_cnt",   int'(frame_cnt),   m_frm);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_sym(input logic [7:0] v);
    seg_in = v;
    @(posedge clk_div8M);
    #1;
  endtask

  // mask bit p set => symbol p replaced by a wrong pattern
  task automatic drive_frame(input logic [15:0] mask);
    for (int p = 0; p < 16; p++)
      drive_sym(mask[p] ? pick_bad(seg_of(p)) : seg_of(p));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " dec_val"},     int'(dec_val),     0);
    chk({tag, " dec_vld"},     int'(dec_vld),     0);
    chk({tag, " dec_illegal"}, int'(dec_illegal), 0);
    chk({tag, " locked"},      int'(locked),      0);
    chk({tag, " err_flag"},    int'(err_flag),    0);
    chk({tag, " err_cnt"},     int'(err_cnt),     0);
    chk({tag, " frame_cnt"},   int'(frame_cnt),   0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] m;
    int a, b;
    rstn = 1'b0;
    seg_in = 8'h00;
    repeat (3) @(posedge clk_div8M);
    #1;
    chk_all_zero("reset");
    rstn = 1'b1;
    cmp_en = 1;

    // clean sequence: lock on frame 2, frames 2,3 counted so far
    repeat (4) drive_frame(16'h0000);
    chk("clean locked", int'(locked), 1);
    chk("clean err_cnt", int'(err_cnt), 0);
    chk("clean frame_cnt", int'(frame_cnt), 2);

    // digit 5 replaced by 00
    for (int p = 0; p < 16; p++) drive_sym(p == 5 ? 8'h00 : seg_of(p));
    drive_frame(16'h0000);
    chk("single err_cnt", int'(err_cnt), 1);
    chk("single locked", int'(locked), 1);
    chk("single frame_cnt", int'(frame_cnt), 3);
`ifdef NUM_SEG_RX_ERR_STICKY_EN
    chk("single err_flag sticky", int'(err_flag), 1);
`else
    chk("single err_flag pulse over", int'(err_flag), 0);
`endif

    // three consecutive mismatches lose lock, clean frame relocks
    drive_frame(16'h001C);
    chk("loss locked", int'(locked), 0);
    chk("loss err_cnt", int'(err_cnt), 4);
    chk("loss frame_cnt", int'(frame_cnt), 4);
    drive_frame(16'h0000);
    chk("relock locked", int'(locked), 1);

    // two errors per frame saturate err_cnt without losing lock
    for (int f = 0; f < 130; f++) begin
      a = $urandom_range(1, 14);
      b = $urandom_range(1, 14);
      while (b == a) b = $urandom_range(1, 14);
      m = 16'h0000;
      m[a] = 1'b1;
      m[b] = 1'b1;
      drive_frame(m);
    end
    chk("sat err_cnt", int'(err_cnt), 255);
    chk("sat locked", int'(locked), 1);
    chk("sat frame_cnt", int'(frame_cnt), 5);

    // random sparse corruption, model-checked
    for (int f = 0; f < 20; f++) begin
      m = 16'h0000;
      for (int p = 0; p < 16; p++) m[p] = ($urandom_range(0, 19) == 0);
      drive_frame(m);
    end

    // mid-frame reset
    for (int p = 0; p < 7; p++) drive_sym(seg_of(p));
    #2;
    rstn = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(posedge clk_div8M);
    @(posedge clk_div8M);
    #1;
    rstn = 1'b1;
    drive_frame(16'h0000);
    drive_frame(16'h0000);
    chk("postreset locked", int'(locked), 1);
    chk("postreset err_flag", int'(err_flag), 0);
    chk("postreset err_cnt", int'(err_cnt), 0);

    // one bad symbol to exercise err_flag behaviour
    drive_frame(16'h0100);
    drive_frame(16'h0000);
`ifdef NUM_SEG_RX_ERR_STICKY_EN
    chk("flag err_flag sticky", int'(err_flag), 1);
`else
    chk("flag err_flag pulse over", int'(err_flag), 0);
`endif
    chk("flag err_cnt", int'(err_cnt), 1);

    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
